// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and helpers for the APB request arbiter slice.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester command/response bus plus APB master signals, bundled for the arbiter.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  import apb_ctrl_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;

  logic                      rsp_valid;
  logic [IDW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  // Arbiter side: accepts commands, drives APB and responses.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // Environment side: requesters and APB fabric.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_req_arbiter_rr.sv
// Combinational round-robin pick: search starts at ptr and wraps.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               found
);

  logic [IDW:0] cand;

  // First requester at or after ptr (modulo NUM_REQ) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[IDW-1:0]]  = 1'b1;
        idx                   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin multi-requester APB master: one transfer in flight, wait-state
// tolerant, with an ACCESS-phase timeout that aborts hung slaves.
module apb_req_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_req_arbiter_if.master bus
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);

  state_t             state, state_nx;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     cur_id;
  logic [IDW-1:0]     gidx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic [CW-1:0]      wait_cnt;
  logic               wait_expired;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .found (any_req)
  );

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Handshake only in IDLE and never while reset is asserted.
  assign bus.req_ready = (state == IDLE && PRESETn) ? grant : '0;
  assign bus.PSEL      = (state != IDLE);
  assign bus.PENABLE   = (state == ACCESS);

  // Next-state decode; PREADY wins over an expiring wait counter.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (bus.PREADY || wait_expired) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  // Command capture, rr pointer, wait counter and one-cycle response.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ptr             <= '0;
      cur_id          <= '0;
      wait_cnt        <= '0;
      bus.PADDR       <= '0;
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.PADDR  <= bus.req_addr[gidx*ADDR_W +: ADDR_W];
            bus.PWDATA <= bus.req_wdata[gidx*DATA_W +: DATA_W];
            bus.PWRITE <= bus.req_write[gidx];
            cur_id     <= gidx;
            ptr        <= (gidx == ID_LAST) ? '0 : gidx + 1'b1;
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          if (bus.PREADY) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err   <= bus.PSLVERR;
          end else if (wait_expired) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_id      <= cur_id;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed and randomized checks of apb_req_arbiter against a transaction model.
module tb_apb_req_arbiter;

  localparam int N       = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic PCLK;
  logic PRESETn;

  apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_req_arbiter #(
    .NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester model: pending commands per requester, rr pointer.
  bit                pend   [N];
  bit                m_wr   [N];
  logic [ADDR_W-1:0] m_addr [N];
  logic [DATA_W-1:0] m_wdata[N];
  int                ptr_m;

  // Expected response for the cycle after the current transfer.
  bit                exp_rv;
  int                exp_id;
  logic [DATA_W-1:0] exp_rdata;
  bit                exp_err;
  bit                exp_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    pend[i]    = 1'b1;
    m_wr[i]    = wr;
    m_addr[i]  = a;
    m_wdata[i] = d;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]                  = pend[i];
      bus.req_write[i]                  = m_wr[i];
      bus.req_addr[i*ADDR_W +: ADDR_W]  = m_addr[i];
      bus.req_wdata[i*DATA_W +: DATA_W] = m_wdata[i];
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic check_rsp(input string ph);
    chk({ph, ".rsp_valid"},   bus.rsp_valid,   exp_rv);
    chk({ph, ".rsp_id"},      bus.rsp_id,      exp_rv ? exp_id : 0);
    chk({ph, ".rsp_rdata"},   bus.rsp_rdata,   exp_rv ? exp_rdata : 0);
    chk({ph, ".rsp_err"},     bus.rsp_err,     exp_rv ? exp_err : 0);
    chk({ph, ".rsp_timeout"}, bus.rsp_timeout, exp_rv ? exp_to : 0);
  endtask

  // Entered just after a rising edge with pend[] holding the requests for
  // this cycle; returns just after the edge that starts the response cycle.
  task automatic run_xfer(input int w, input logic [DATA_W-1:0] prd, input bit serr,
                          input bit keep);
    int                win;
    int                k;
    bit                done;
    bit                w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    win = model_pick();
    apply_reqs();
    @(negedge PCLK);
    check_rsp("idle");
    chk("idle.PSEL", bus.PSEL, 1'b0);
    chk("idle.req_ready", bus.req_ready, (win < 0) ? 0 : (64'd1 << win));
    if (win < 0) return;
    w_wr   = m_wr[win];
    w_addr = m_addr[win];
    w_data = m_wdata[win];
    @(posedge PCLK); #1;
    ptr_m = (win + 1) % N;
    if (keep) set_cmd(win, 1'($urandom_range(0, 1)), $urandom, $urandom);
    else      pend[win] = 1'b0;
    apply_reqs();
    exp_rv = 1'b0;
    @(negedge PCLK);
    chk("setup.PSEL", bus.PSEL, 1'b1);
    chk("setup.PENABLE", bus.PENABLE, 1'b0);
    chk("setup.req_ready", bus.req_ready, 0);
    chk("setup.PADDR", bus.PADDR, w_addr);
    chk("setup.PWRITE", bus.PWRITE, w_wr);
    chk("setup.PWDATA", bus.PWDATA, w_data);
    chk("setup.rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge PCLK); #1;
    k    = 0;
    done = 1'b0;
    while (!done) begin
      bus.PREADY  = (k == w);
      bus.PRDATA  = (k == w) ? prd : DATA_W'($urandom);
      bus.PSLVERR = (k == w) ? serr : 1'($urandom_range(0, 1));
      @(negedge PCLK);
      chk("access.PSEL_PENABLE", {bus.PSEL, bus.PENABLE}, 2'b11);
      chk("access.req_ready", bus.req_ready, 0);
      chk("access.rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge PCLK); #1;
      if (k == w || k == TIMEOUT - 1) done = 1'b1;
      else k++;
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    exp_rv = 1'b1;
    exp_id = win;
    if (w < TIMEOUT) begin
      exp_rdata = w_wr ? '0 : prd;
      exp_err   = serr;
      exp_to    = 1'b0;
    end else begin
      exp_rdata = '0;
      exp_err   = 1'b1;
      exp_to    = 1'b1;
    end
  endtask

  // Consumes one cycle with no requests, checking any pending response.
  task automatic finish_rsp();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    apply_reqs();
    @(negedge PCLK);
    check_rsp("drain");
    chk("drain.PSEL", bus.PSEL, 1'b0);
    chk("drain.req_ready", bus.req_ready, 0);
    @(posedge PCLK); #1;
    exp_rv = 1'b0;
  endtask

  int wsel[9] = '{0, 0, 1, 2, 3, TIMEOUT-2, TIMEOUT-1, TIMEOUT, TIMEOUT+3};

  initial begin
    PRESETn       = 1'b0;
    bus.req_valid = '1;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
    end
    ptr_m = 0; exp_rv = 1'b0; exp_id = 0; exp_rdata = '0; exp_err = 1'b0; exp_to = 1'b0;

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst.req_ready", bus.req_ready, 0);
    chk("rst.PSEL", bus.PSEL, 1'b0);
    chk("rst.PENABLE", bus.PENABLE, 1'b0);
    chk("rst.PADDR", bus.PADDR, 0);
    chk("rst.PWRITE", bus.PWRITE, 0);
    chk("rst.PWDATA", bus.PWDATA, 0);
    check_rsp("rst");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // All requesters continuously valid: grant order 0,1,2,3,0 every 3 cycles.
    for (int i = 0; i < N; i++) set_cmd(i, 1'(i % 2), 32'h100 + i, 32'hA000 + i);
    for (int t = 0; t < 5; t++) run_xfer(0, 32'hC0DE_0000 + t, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Single zero-wait write from requester 0.
    set_cmd(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    run_xfer(0, 32'h5555_AAAA, 1'b0, 1'b0);

    // Read from requester 2 with three wait states.
    set_cmd(2, 1'b0, 32'h0000_0200, 32'h0);
    run_xfer(3, 32'h1234_5678, 1'b0, 1'b0);

    // PREADY never rises: timeout abort.
    set_cmd(1, 1'b0, 32'h0000_0300, 32'h0);
    run_xfer(TIMEOUT, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Slave error on a write.
    set_cmd(3, 1'b1, 32'h0000_0400, 32'h0BAD_F00D);
    run_xfer(1, 32'h7777_7777, 1'b1, 1'b0);

    // PREADY on the last allowed cycle completes normally.
    set_cmd(0, 1'b0, 32'h0000_0500, 32'h0);
    run_xfer(TIMEOUT - 1, 32'h8765_4321, 1'b0, 1'b0);

    // Reset in the middle of ACCESS: no response, pointer back to 0.
    finish_rsp();
    set_cmd(1, 1'b1, 32'h0000_0600, 32'h1111_1111);
    apply_reqs();
    @(posedge PCLK); #1;
    pend[1] = 1'b0;
    apply_reqs();
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("midrst.access_before_edge", bus.PENABLE, 1'b1);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("midrst.PSEL", bus.PSEL, 1'b0);
    chk("midrst.PENABLE", bus.PENABLE, 1'b0);
    chk("midrst.rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    ptr_m  = 0;
    exp_rv = 1'b0;
    set_cmd(3, 1'b0, 32'h0000_0700, 32'h0);
    set_cmd(0, 1'b1, 32'h0000_0800, 32'h2222_2222);
    run_xfer(0, 32'h3333_3333, 1'b0, 1'b0);
    pend[3] = 1'b0;

    // Randomized traffic against the transaction model.
    for (int t = 0; t < 60; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        any |= pend[i];
      end
      if (!any) set_cmd($urandom_range(0, N-1), 1'($urandom_range(0, 1)), $urandom, $urandom);
      run_xfer(wsel[$urandom_range(0, 8)], $urandom, ($urandom_range(0, 3) == 0), 1'b0);
    end

    finish_rsp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
